// File: rtl/link_init_negotiator.sv
// link_init_negotiator
//   Host-link bring-up FSM between the byte-level UART handshake ports and
//   the sample datapath. It hunts for MAGIC in the rx stream, replies with
//   ID_STR, receives a little-endian sample rate of RATE_BYTES bytes, matches
//   it against RATE_TABLE and replies "OK\n" or "ERROR\n".
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   restart         soft restart pulse (rate outputs and flags are kept)
//   rx_rq/rx_data   rx byte request (async 4-phase) and its data
//   rx_st           rx acknowledge
//   tx_rq/tx_data   tx byte request (4-phase) and its data
//   tx_st           tx acknowledge (async)
//   rate_sel        index of the matched RATE_TABLE entry
//   samp_rate       negotiated rate, zero-extended
//   best_eff        rate 0 negotiated in best-effort mode
//   init_ok         sticky success flag
//   init_err        sticky invalid-rate flag
//   timeout_p       one-cycle pulse when the rate bytes stop arriving
module link_init_negotiator #(
  parameter int                    MAGIC_LEN  = 3,
  parameter logic [63:0]           MAGIC      = 64'h55544E,
  parameter int                    ID_LEN     = 6,
  parameter logic [63:0]           ID_STR     = 64'h55544E76320A,
  parameter int                    RATE_BYTES = 2,
  parameter int                    N_RATES    = 8,
  parameter logic [32*N_RATES-1:0] RATE_TABLE = {32'd48000, 32'd44100, 32'd32000, 32'd24000,
                                                 32'd22050, 32'd16000, 32'd11025, 32'd8000},
  parameter bit                    BEST_EFF   = 1'b1,
  parameter logic [23:0]           TIMEOUT    = 24'd12_000_000,
  localparam int                   SELW       = $clog2(N_RATES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            restart,
  input  logic            rx_rq,
  input  logic [7:0]      rx_data,
  output logic            rx_st,
  output logic            tx_rq,
  output logic [7:0]      tx_data,
  input  logic            tx_st,
  output logic [SELW-1:0] rate_sel,
  output logic [31:0]     samp_rate,
  output logic            best_eff,
  output logic            init_ok,
  output logic            init_err,
  output logic            timeout_p
);

  localparam logic [63:0] OK_STR  = 64'h4F4B0A;        // "OK\n"
  localparam logic [63:0] ERR_STR = 64'h4552524F520A;  // "ERROR\n"

  typedef enum logic [2:0] {HUNT, SEND_ID, RX_RATE, CHECK, SEND_OK, SEND_ERR} state_t;

  // Byte k of a string whose first byte sits in the top occupied byte.
  function automatic logic [7:0] str_byte(input logic [63:0] s, input int len,
                                          input logic [3:0] k);
    int         sh;
    logic [7:0] b;
    sh = 8 * (len - 1 - int'(k));
    b  = 8'h00;
    if (sh >= 0 && sh <= 56) b = s[sh +: 8];
    return b;
  endfunction

  state_t         state, state_n;
  logic [3:0]     idx, idx_n;          // magic position / tx byte / rate byte, per state
  logic [23:0]    to_cnt, to_cnt_n;
  logic [1:0]     rx_sync, tx_sync;
  logic           rx_rq_s, tx_st_s;
  logic           rx_st_n, tx_rq_n, timeout_p_n;
  logic [7:0]     rx_byte, rx_byte_n, tx_data_n;
  logic [31:0]    rate_tmp, rate_tmp_n, samp_rate_n;
  logic [SELW-1:0] rate_sel_n;
  logic           best_eff_n, init_ok_n, init_err_n;

  logic           rx_acc, tx_active, tx_go, tx_ack, tx_last;
  logic [3:0]     tx_len;
  logic [7:0]     tx_byte, magic_byte, magic_first;
  logic           hit;
  logic [SELW-1:0] hit_idx;

  assign rx_rq_s     = rx_sync[1];
  assign tx_st_s     = tx_sync[1];
  // A byte counts as received only once the sender has released rx_rq.
  assign rx_acc      = rx_st && !rx_rq_s;
  assign magic_byte  = str_byte(MAGIC, MAGIC_LEN, idx);
  assign magic_first = str_byte(MAGIC, MAGIC_LEN, 4'd0);
  assign tx_active   = (state == SEND_ID) || (state == SEND_OK) || (state == SEND_ERR);
  assign tx_go       = tx_active && !tx_rq && !tx_st_s;
  assign tx_ack      = tx_active && tx_rq && tx_st_s;
  assign tx_last     = (idx == tx_len - 4'd1);

  always_comb begin
    tx_len  = 4'd1;
    tx_byte = 8'h00;
    case (state)
      SEND_ID:  begin tx_len = 4'(ID_LEN); tx_byte = str_byte(ID_STR, ID_LEN, idx); end
      SEND_OK:  begin tx_len = 4'd3;       tx_byte = str_byte(OK_STR, 3, idx);      end
      SEND_ERR: begin tx_len = 4'd6;       tx_byte = str_byte(ERR_STR, 6, idx);     end
      default:  ;
    endcase
  end

  // Scan downwards so the lowest matching entry wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_RATES - 1; i >= 0; i--) begin
      if (RATE_TABLE[32*i +: 32] == rate_tmp) begin
        hit     = 1'b1;
        hit_idx = SELW'(i);
      end
    end
  end

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    to_cnt_n    = to_cnt;
    rx_st_n     = rx_st;
    rx_byte_n   = rx_byte;
    tx_rq_n     = tx_rq;
    tx_data_n   = tx_data;
    rate_tmp_n  = rate_tmp;
    timeout_p_n = 1'b0;
    rate_sel_n  = rate_sel;
    samp_rate_n = samp_rate;
    best_eff_n  = best_eff;
    init_ok_n   = init_ok;
    init_err_n  = init_err;

    // rx handshake runs in every state; bytes outside HUNT/RX_RATE are dropped
    if (rx_rq_s && !rx_st) begin
      rx_st_n   = 1'b1;
      rx_byte_n = rx_data;
    end else if (!rx_rq_s && rx_st) begin
      rx_st_n = 1'b0;
    end

    if (tx_go) begin
      tx_data_n = tx_byte;
      tx_rq_n   = 1'b1;
    end
    if (tx_ack) begin
      tx_rq_n = 1'b0;
      idx_n   = tx_last ? 4'd0 : idx + 4'd1;
    end

    case (state)
      HUNT: if (rx_acc) begin
        if (rx_byte == magic_byte) begin
          if (idx == 4'(MAGIC_LEN - 1)) begin
            state_n    = SEND_ID;
            idx_n      = 4'd0;
            init_ok_n  = 1'b0;
            init_err_n = 1'b0;
          end else begin
            idx_n = idx + 4'd1;
          end
        end else begin
          // a mismatching byte may itself start a new magic
          idx_n = (rx_byte == magic_first) ? 4'd1 : 4'd0;
        end
      end
      SEND_ID: if (tx_ack && tx_last) begin
        state_n    = RX_RATE;
        to_cnt_n   = '0;
        rate_tmp_n = '0;
      end
      RX_RATE: begin
        if (rx_acc) begin
          rate_tmp_n[{idx[1:0], 3'b000} +: 8] = rx_byte;
          to_cnt_n = '0;
          if (idx == 4'(RATE_BYTES - 1)) begin
            state_n = CHECK;
            idx_n   = 4'd0;
          end else begin
            idx_n = idx + 4'd1;
          end
        end else if (TIMEOUT != 24'd0) begin
          if (to_cnt == TIMEOUT - 24'd1) begin
            timeout_p_n = 1'b1;
            state_n     = HUNT;
            idx_n       = 4'd0;
            to_cnt_n    = '0;
          end else begin
            to_cnt_n = to_cnt + 24'd1;
          end
        end
      end
      CHECK: begin
        idx_n = 4'd0;
        if (hit) begin
          rate_sel_n  = hit_idx;
          samp_rate_n = rate_tmp;
          best_eff_n  = 1'b0;
          state_n     = SEND_OK;
        end else if (BEST_EFF && rate_tmp == 32'd0) begin
          rate_sel_n  = '0;
          samp_rate_n = rate_tmp;
          best_eff_n  = 1'b1;
          state_n     = SEND_OK;
        end else begin
          state_n = SEND_ERR;
        end
      end
      SEND_OK: if (tx_ack && tx_last) begin
        init_ok_n = 1'b1;
        state_n   = HUNT;
      end
      SEND_ERR: if (tx_ack && tx_last) begin
        init_err_n = 1'b1;
        state_n    = HUNT;
      end
      default: state_n = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      idx       <= '0;
      to_cnt    <= '0;
      rx_sync   <= '0;
      tx_sync   <= '0;
      rx_st     <= 1'b0;
      rx_byte   <= '0;
      tx_rq     <= 1'b0;
      tx_data   <= '0;
      rate_tmp  <= '0;
      timeout_p <= 1'b0;
      rate_sel  <= '0;
      samp_rate <= '0;
      best_eff  <= 1'b0;
      init_ok   <= 1'b0;
      init_err  <= 1'b0;
    end else if (restart) begin
      // negotiated results survive a soft restart
      state     <= HUNT;
      idx       <= '0;
      to_cnt    <= '0;
      rx_sync   <= '0;
      tx_sync   <= '0;
      rx_st     <= 1'b0;
      rx_byte   <= '0;
      tx_rq     <= 1'b0;
      tx_data   <= '0;
      rate_tmp  <= '0;
      timeout_p <= 1'b0;
    end else begin
      rx_sync   <= {rx_sync[0], rx_rq};
      tx_sync   <= {tx_sync[0], tx_st};
      state     <= state_n;
      idx       <= idx_n;
      to_cnt    <= to_cnt_n;
      rx_st     <= rx_st_n;
      rx_byte   <= rx_byte_n;
      tx_rq     <= tx_rq_n;
      tx_data   <= tx_data_n;
      rate_tmp  <= rate_tmp_n;
      timeout_p <= timeout_p_n;
      rate_sel  <= rate_sel_n;
      samp_rate <= samp_rate_n;
      best_eff  <= best_eff_n;
      init_ok   <= init_ok_n;
      init_err  <= init_err_n;
    end
  end

endmodule

// File: tb/tb_link_init_negotiator.sv
// tb_link_init_negotiator
//   Two instances share the rx stream: dut_a accepts rate 0 as best-effort,
//   dut_b does not. Both use a short rx timeout. Independent tx responders
//   log every transmitted byte; a rate-table model predicts replies and flags.
module tb_link_init_negotiator;
  localparam int RATE_BYTES = 2;

  logic clk = 1'b0;
  logic rst, restart, rx_rq, tx_en;
  logic [7:0] rx_data;
  logic rx_st_a, tx_rq_a, tx_st_a, best_eff_a, init_ok_a, init_err_a, timeout_p_a;
  logic rx_st_b, tx_rq_b, tx_st_b, best_eff_b, init_ok_b, init_err_b, timeout_p_b;
  logic [7:0] tx_data_a, tx_data_b;
  logic [2:0] rate_sel_a, rate_sel_b;
  logic [31:0] samp_rate_a, samp_rate_b;

  logic [7:0] qa[$], qb[$];
  int n_checks = 0, n_pass = 0;

  logic [7:0] magic_s[3] = '{8'h55, 8'h54, 8'h4E};
  logic [7:0] id_s[6]    = '{8'h55, 8'h54, 8'h4E, 8'h76, 8'h32, 8'h0A};
  logic [7:0] ok_s[3]    = '{8'h4F, 8'h4B, 8'h0A};
  logic [7:0] err_s[6]   = '{8'h45, 8'h52, 8'h52, 8'h4F, 8'h52, 8'h0A};
  int unsigned tbl[8]    = '{8000, 11025, 16000, 22050, 24000, 32000, 44100, 48000};
  bit be_par[2]          = '{1'b1, 1'b0};

  logic [2:0]  m_sel[2];
  logic [31:0] m_samp[2];
  logic        m_be[2], m_ok[2], m_err[2];
  bit          m_rok[2];

  always #5 clk = ~clk;

  link_init_negotiator #(.BEST_EFF(1'b1), .TIMEOUT(24'd100)) dut_a (
    .clk(clk), .rst(rst), .restart(restart), .rx_rq(rx_rq), .rx_data(rx_data),
    .rx_st(rx_st_a), .tx_rq(tx_rq_a), .tx_data(tx_data_a), .tx_st(tx_st_a),
    .rate_sel(rate_sel_a), .samp_rate(samp_rate_a), .best_eff(best_eff_a),
    .init_ok(init_ok_a), .init_err(init_err_a), .timeout_p(timeout_p_a));

  link_init_negotiator #(.BEST_EFF(1'b0), .TIMEOUT(24'd100)) dut_b (
    .clk(clk), .rst(rst), .restart(restart), .rx_rq(rx_rq), .rx_data(rx_data),
    .rx_st(rx_st_b), .tx_rq(tx_rq_b), .tx_data(tx_data_b), .tx_st(tx_st_b),
    .rate_sel(rate_sel_b), .samp_rate(samp_rate_b), .best_eff(best_eff_b),
    .init_ok(init_ok_b), .init_err(init_err_b), .timeout_p(timeout_p_b));

  initial begin
    tx_st_a = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_rq_a === 1'b1 && tx_en && !tx_st_a) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if (tx_rq_a === 1'b1) begin
          qa.push_back(tx_data_a);
          tx_st_a = 1'b1;
          for (int n = 0; n < 200 && tx_rq_a !== 1'b0; n++) @(negedge clk);
          repeat ($urandom_range(0, 3)) @(negedge clk);
          tx_st_a = 1'b0;
        end
      end
    end
  end

  initial begin
    tx_st_b = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_rq_b === 1'b1 && !tx_st_b) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if (tx_rq_b === 1'b1) begin
          qb.push_back(tx_data_b);
          tx_st_b = 1'b1;
          for (int n = 0; n < 200 && tx_rq_b !== 1'b0; n++) @(negedge clk);
          repeat ($urandom_range(0, 3)) @(negedge clk);
          tx_st_b = 1'b0;
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_sel[d] = '0; m_samp[d] = '0; m_be[d] = 1'b0; m_ok[d] = 1'b0; m_err[d] = 1'b0;
    end
  endtask

  task automatic model_rate(input int d, input logic [31:0] v);
    int found;
    found = -1;
    for (int i = 0; i < 8; i++) if (found < 0 && tbl[i] == v) found = i;
    if (found >= 0) begin
      m_sel[d] = 3'(found); m_samp[d] = v; m_be[d] = 1'b0; m_ok[d] = 1'b1; m_rok[d] = 1'b1;
    end else if (v == 32'd0 && be_par[d]) begin
      m_sel[d] = '0; m_samp[d] = '0; m_be[d] = 1'b1; m_ok[d] = 1'b1; m_rok[d] = 1'b1;
    end else begin
      m_err[d] = 1'b1; m_rok[d] = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    rx_data = b;
    rx_rq   = 1'b1;
    n = 0;
    while (rx_st_a !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    rx_rq = 1'b0;
    n = (n >= 100) ? 1000 : 0;
    while (rx_st_a !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      n_checks++;
      $display("FAIL rx_handshake byte %02h: rx_st stuck, required a 4-phase ack", b);
    end
  endtask

  task automatic wait_tx(input int na, input int nb);
    int n, idle;
    n = 0;
    while ((qa.size() < na || qb.size() < nb) && n < 3000) begin @(negedge clk); n++; end
    idle = 0;
    while (idle < 6 && n < 3000) begin
      @(negedge clk); n++;
      if (!tx_rq_a && !tx_rq_b && !tx_st_a && !tx_st_b) idle++; else idle = 0;
    end
    if (n >= 3000) begin
      n_checks++;
      $display("FAIL tx_wait: got %0d/%0d bytes, required %0d/%0d and idle",
               qa.size(), qb.size(), na, nb);
    end
  endtask

  task automatic run_session(input logic [7:0] pre[$], input logic [31:0] rate, input string tag);
    int ba, bb, len;
    logic [7:0] got, want;
    ba = qa.size(); bb = qb.size();
    foreach (pre[i]) send_byte(pre[i]);
    for (int i = 0; i < 3; i++) send_byte(magic_s[i]);
    for (int d = 0; d < 2; d++) begin m_ok[d] = 1'b0; m_err[d] = 1'b0; end
    wait_tx(ba + 6, bb + 6);
    for (int i = 0; i < RATE_BYTES; i++) send_byte(rate[8*i +: 8]);
    for (int d = 0; d < 2; d++) model_rate(d, rate);
    wait_tx(ba + 6 + (m_rok[0] ? 3 : 6), bb + 6 + (m_rok[1] ? 3 : 6));
    for (int d = 0; d < 2; d++) begin
      len = 6 + (m_rok[d] ? 3 : 6);
      for (int k = 0; k < len; k++) begin
        if (d == 0) got = (ba + k < qa.size()) ? qa[ba + k] : 8'hxx;
        else        got = (bb + k < qb.size()) ? qb[bb + k] : 8'hxx;
        want = (k < 6) ? id_s[k] : (m_rok[d] ? ok_s[(k - 6) % 3] : err_s[k - 6]);
        n_checks++;
        if (got !== want) $display("FAIL %s dut%0d tx[%0d]: got %02h required %02h", tag, d, k, got, want);
        else n_pass++;
      end
      n_checks++;
      if ((d ? rate_sel_b : rate_sel_a) !== m_sel[d])
        $display("FAIL %s dut%0d rate_sel: got %0d required %0d", tag, d, d ? rate_sel_b : rate_sel_a, m_sel[d]);
      else n_pass++;
      n_checks++;
      if ((d ? samp_rate_b : samp_rate_a) !== m_samp[d])
        $display("FAIL %s dut%0d samp_rate: got %0d required %0d", tag, d, d ? samp_rate_b : samp_rate_a, m_samp[d]);
      else n_pass++;
      n_checks++;
      if ((d ? best_eff_b : best_eff_a) !== m_be[d])
        $display("FAIL %s dut%0d best_eff: got %0b required %0b", tag, d, d ? best_eff_b : best_eff_a, m_be[d]);
      else n_pass++;
      n_checks++;
      if ((d ? init_ok_b : init_ok_a) !== m_ok[d])
        $display("FAIL %s dut%0d init_ok: got %0b required %0b", tag, d, d ? init_ok_b : init_ok_a, m_ok[d]);
      else n_pass++;
      n_checks++;
      if ((d ? init_err_b : init_err_a) !== m_err[d])
        $display("FAIL %s dut%0d init_err: got %0b required %0b", tag, d, d ? init_err_b : init_err_a, m_err[d]);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; restart = 1'b0; rx_rq = 1'b0; rx_data = 8'h00; tx_en = 1'b1;
    repeat (5) @(negedge clk);
    model_reset();
    n_checks++;
    if ({rx_st_a, tx_rq_a, tx_data_a, rate_sel_a, samp_rate_a, best_eff_a, init_ok_a, init_err_a, timeout_p_a} !== '0)
      $display("FAIL reset_outputs: got %h required 0", {rx_st_a, tx_rq_a, tx_data_a, rate_sel_a,
               samp_rate_a, best_eff_a, init_ok_a, init_err_a, timeout_p_a});
    else n_pass++;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({rx_st_a, tx_rq_a, init_ok_a, init_err_a, timeout_p_a} !== 5'b0)
      $display("FAIL reset_idle: got %b required 00000", {rx_st_a, tx_rq_a, init_ok_a, init_err_a, timeout_p_a});
    else n_pass++;
  endtask

  task automatic test_directed();
    logic [7:0] q0[$], qu[$];
    qu.push_back(8'h55);
    run_session(q0, 32'd8000,  "basic_8000");
    run_session(q0, 32'd10000, "bad_rate");
    run_session(qu, 32'd44100, "overlap_UUTN");
    run_session(q0, 32'd0,     "best_effort");
    run_session(q0, 32'd48000, "table_top");
  endtask

  task automatic test_timeout();
    int ba, bb, n;
    logic [7:0] q0[$];
    ba = qa.size(); bb = qb.size();
    for (int i = 0; i < 3; i++) send_byte(magic_s[i]);
    for (int d = 0; d < 2; d++) begin m_ok[d] = 1'b0; m_err[d] = 1'b0; end
    wait_tx(ba + 6, bb + 6);
    rx_data = 8'h40;
    rx_rq   = 1'b1;
    n = 0;
    while (rx_st_a !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    rx_rq = 1'b0;
    n = 0;
    while (rx_st_a !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (n < 300) begin
      @(negedge clk); n++;
      if (timeout_p_a === 1'b1) break;
    end
    n_checks++;
    if (n !== 100) $display("FAIL timeout_cycle: pulse after %0d cycles, required 100", n);
    else n_pass++;
    n_checks++;
    if (timeout_p_b !== 1'b1) $display("FAIL timeout_b: got %0b required 1", timeout_p_b);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (timeout_p_a !== 1'b0) $display("FAIL timeout_width: got %0b required 0", timeout_p_a);
    else n_pass++;
    n_checks++;
    if ({init_ok_a, init_err_a, samp_rate_a} !== {m_ok[0], m_err[0], m_samp[0]})
      $display("FAIL timeout_flags: got %0b%0b %0d required %0b%0b %0d", init_ok_a, init_err_a,
               samp_rate_a, m_ok[0], m_err[0], m_samp[0]);
    else n_pass++;
    run_session(q0, 32'd16000, "after_timeout");
  endtask

  // Stalls the tx side on the third ID byte and then fires rst or restart.
  task automatic stall_mid_id(input bit use_rst);
    int ba, n;
    ba = qa.size();
    for (int i = 0; i < 3; i++) send_byte(magic_s[i]);
    for (int d = 0; d < 2; d++) begin m_ok[d] = 1'b0; m_err[d] = 1'b0; end
    n = 0;
    while (qa.size() < ba + 2 && n < 2000) begin @(negedge clk); n++; end
    tx_en = 1'b0;
    while (!(tx_rq_a === 1'b1 && tx_st_a === 1'b0) && n < 2000) begin @(negedge clk); n++; end
    n_checks++;
    if (tx_rq_a !== 1'b1) $display("FAIL stall_tx_rq: got %0b required 1", tx_rq_a);
    else n_pass++;
    if (use_rst) rst = 1'b1; else restart = 1'b1;
    @(negedge clk);
    rst = 1'b0; restart = 1'b0;
    if (use_rst) model_reset();
    n_checks++;
    if (tx_rq_a !== 1'b0) $display("FAIL %s_tx_rq: got %0b required 0", use_rst ? "rst" : "restart", tx_rq_a);
    else n_pass++;
    n_checks++;
    if ({rate_sel_a, samp_rate_a, best_eff_a, init_ok_a, init_err_a} !==
        {m_sel[0], m_samp[0], m_be[0], m_ok[0], m_err[0]})
      $display("FAIL %s_kept: got sel %0d rate %0d be %0b ok %0b err %0b required %0d %0d %0b %0b %0b",
               use_rst ? "rst" : "restart", rate_sel_a, samp_rate_a, best_eff_a, init_ok_a, init_err_a,
               m_sel[0], m_samp[0], m_be[0], m_ok[0], m_err[0]);
    else n_pass++;
    tx_en = 1'b1;
    wait_tx(0, 0);
  endtask

  task automatic test_reset_restart_mid_tx();
    logic [7:0] q0[$];
    stall_mid_id(1'b1);
    run_session(q0, 32'd44100, "after_rst");
    stall_mid_id(1'b0);
    run_session(q0, 32'd22050, "after_restart");
  endtask

  task automatic test_random();
    logic [7:0] pre[$];
    logic [31:0] rate;
    bit clean;
    for (int s = 0; s < 12; s++) begin
      do begin
        pre.delete();
        repeat ($urandom_range(0, 5)) begin
          case ($urandom_range(0, 3))
            0: pre.push_back(8'h55);
            1: pre.push_back(8'h54);
            2: pre.push_back(8'h4E);
            default: pre.push_back(8'($urandom_range(0, 255)));
          endcase
        end
        clean = 1'b1;
        for (int i = 0; i + 2 < pre.size(); i++)
          if (pre[i] == 8'h55 && pre[i+1] == 8'h54 && pre[i+2] == 8'h4E) clean = 1'b0;
      end while (!clean);
      if ($urandom_range(0, 1) == 0) rate = tbl[$urandom_range(0, 7)];
      else rate = $urandom_range(0, 65535);
      run_session(pre, rate, $sformatf("random%0d", s));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_reset_restart_mid_tx();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
